fp32_vec_minmax: RTL and testbench
==================================

FP32_VEC_MINMAX -- requirements
Module: fp32_vec_minmax

Interface
REQ-001 Parameter IDX_W, default 8: width of the element index and count; the maximum vector length is 2^IDX_W.
REQ-002 Parameter QNAN, default 32'h7FC0_0000: canonical NaN value returned when a NaN is seen.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset_n, input, 1: reset, synchronous, active-low.
REQ-005 Port is_max, input, 1: 1 selects maximum, 0 selects minimum; sampled with the first element of each vector.
REQ-006 Port in_valid, input, 1: in_data is valid this cycle.
REQ-007 Port in_ready, output, 1: the block can accept an element this cycle.
REQ-008 Port in_data, input, 32: IEEE-754 binary32 element.
REQ-009 Port in_last, input, 1: marks the final element of the vector.
REQ-010 Port out_valid, output, 1: result fields are valid.
REQ-011 Port out_ready, input, 1: the consumer accepts the result.
REQ-012 Port out_data, output, 32: selected min/max value.
REQ-013 Port out_idx, output, IDX_W: zero-based index of out_data within the vector.
REQ-014 Port out_cnt, output, IDX_W+1: number of elements accepted for this vector.
REQ-015 Port nan_err, output, 1: at least one element was NaN; valid with out_valid.
REQ-016 Port ovf_err, output, 1: more than 2^IDX_W elements arrived before in_last; valid with out_valid.

Function
REQ-017 The block SHALL implement an FSM with three states: IDLE (no element yet), ACC (accumulating), DONE (result held).
REQ-018 An element SHALL be accepted when in_valid and in_ready are both high; in_ready SHALL be 1 in IDLE and ACC and 0 in DONE.
REQ-019 On acceptance in IDLE, the block SHALL load the accumulator with in_data, set idx=0 and cnt=1, latch is_max, and go to ACC, or to DONE if in_last=1.
REQ-020 On acceptance in ACC, the block SHALL compare in_data against the accumulator using the latched mode, replace the value and index only on strict improvement (ties keep the earlier index), increment cnt, and go to DONE if in_last=1.
REQ-021 Ordering SHALL be total over non-NaN values, including ±Inf and denormals: negatives below positives, magnitude order reversed for negatives, and +0 equal to -0 (a tie).
REQ-022 A NaN is an element with exponent 0xFF and a nonzero mantissa; the first NaN SHALL set the sticky nan flag and freeze the value at QNAN and the index at the NaN's position; later elements SHALL NOT change the value or index.
REQ-023 cnt SHALL saturate at 2^IDX_W; an element accepted while cnt=2^IDX_W SHALL set the sticky ovf flag and SHALL NOT be compared.
REQ-024 In DONE, out_valid SHALL be 1 and out_data, out_idx, out_cnt, nan_err and ovf_err SHALL be stable until out_ready=1.
REQ-025 out_valid SHALL first rise in the cycle after the in_last element is accepted (latency 1 cycle from the last element).
REQ-026 When out_valid and out_ready are both high, the FSM SHALL return to IDLE on that edge and clear the flags; the first element of the next vector can be accepted on the following cycle.
REQ-027 Changes to is_max after the first element SHALL be ignored until the next vector.
REQ-028 A single-element vector (in_last set on the first element) SHALL return that element with idx=0 and cnt=1.
REQ-029 The datapath SHALL be one comparator stage with a registered accumulator; there SHALL be no combinational path from out_ready to in_ready.

Reset
REQ-030 While reset_n=0 at a clock edge, the block SHALL enter IDLE with out_valid=0, out_data=0, out_idx=0, out_cnt=0, nan_err=0, ovf_err=0, in_ready=0.
REQ-031 in_ready SHALL be 1 from the first edge after reset_n returns to 1.
REQ-032 Reset asserted in ACC or DONE SHALL discard the partial vector or the pending result, and no out_valid SHALL be issued for it.

Verification
REQ-033 Max of {16.0, -17.0}, is_max=1 -> out_data=0x41800000, idx=0, cnt=2, nan_err=0.
REQ-034 Min of the same vector with is_max=0 -> out_data=0xC1880000, idx=1; toggling is_max mid-vector has no effect.
REQ-035 Max of {3.0, -Inf, 3.0, -0.0, +0.0} -> 0x40400000, idx=0 (tie keeps the first index); min of {+0.0, -0.0} -> 0x00000000, idx=0.
REQ-036 Max of {1.0, 0x7FC00001, 5.0} -> out_data=QNAN, idx=1, nan_err=1, cnt=3.
REQ-037 With IDX_W=2, send 5 elements with in_last on the 5th -> ovf_err=1, out_cnt=4; hold out_ready=0 for 10 cycles -> outputs stable and in_ready=0.
REQ-038 Assert reset_n=0 for one cycle after 3 elements of a vector -> no out_valid; a following vector {2.0} gives 0x40000000, idx=0, cnt=1.

Source files
------------

// File: rtl/fp32_vec_minmax.sv
// Streaming FP32 vector min/max reducer.
// Reports the winner's value, index and count, plus NaN and overflow flags.
module fp32_vec_minmax #(
    parameter int          IDX_W = 8,
    parameter logic [31:0] QNAN  = 32'h7FC0_0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             is_max,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_cnt,
    output logic             nan_err,
    output logic             ovf_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W:0] CNT_MAX = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic             r_live;
    logic             r_max;
    logic [31:0]      r_acc;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W:0]   r_cnt;
    logic             r_nan;
    logic             r_ovf;

    logic             w_take;
    logic             w_is_nan;
    logic             w_full;
    logic             w_better;
    logic [31:0]      w_key_in;
    logic [31:0]      w_key_acc;

    // Map a float onto an unsigned key whose order is the numeric order; -0 folds onto +0.
    function automatic logic [31:0] f_key(input logic [31:0] x);
        logic [31:0] k;
        if (x[30:0] == 31'd0)
            k = 32'h8000_0000;
        else if (x[31])
            k = ~x;
        else
            k = x | 32'h8000_0000;
        return k;
    endfunction

    assign w_key_in  = f_key(in_data);
    assign w_key_acc = f_key(r_acc);
    assign w_is_nan  = (&in_data[30:23]) && (|in_data[22:0]);
    assign w_full    = (r_cnt == CNT_MAX);
    assign w_better  = r_max ? (w_key_in > w_key_acc) : (w_key_in < w_key_acc);

    assign in_ready  = r_live && (r_state != S_DONE);
    assign w_take    = in_valid && in_ready;

    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_acc;
    assign out_idx   = r_idx;
    assign out_cnt   = r_cnt;
    assign nan_err   = r_nan;
    assign ovf_err   = r_ovf;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
            r_max   <= 1'b0;
            r_acc   <= 32'd0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_nan   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_acc   <= w_is_nan ? QNAN : in_data;
                        r_idx   <= '0;
                        r_cnt   <= CNT_ONE;
                        r_max   <= is_max;
                        r_nan   <= w_is_nan;
                        r_ovf   <= 1'b0;
                        r_state <= in_last ? S_DONE : S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_take) begin
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                            // Once a NaN is seen the value and index are frozen.
                            if (!r_nan) begin
                                if (w_is_nan) begin
                                    r_nan <= 1'b1;
                                    r_acc <= QNAN;
                                    r_idx <= r_cnt[IDX_W-1:0];
                                end else if (w_better) begin
                                    r_acc <= in_data;
                                    r_idx <= r_cnt[IDX_W-1:0];
                                end
                            end
                        end
                        if (in_last)
                            r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                        r_acc   <= 32'd0;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_nan   <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_vec_minmax.sv
// Directed bench for fp32_vec_minmax.
// Instance A uses IDX_W=8, instance B uses IDX_W=2 for overflow cases.
module tb_fp32_vec_minmax;

    logic        clk;
    logic        reset_n;
    logic        is_max;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;
    logic        sel;

    logic        rdy_a, ov_a, nan_a, ovf_a;
    logic [31:0] dat_a;
    logic [7:0]  idx_a;
    logic [8:0]  cnt_a;
    logic        rdy_b, ov_b, nan_b, ovf_b;
    logic [31:0] dat_b;
    logic [1:0]  idx_b;
    logic [2:0]  cnt_b;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_idx;
    logic [8:0]  out_cnt;
    logic        nan_err;
    logic        ovf_err;

    int n_cmp;
    int n_bad;

    fp32_vec_minmax #(.IDX_W(8)) u_a (
        .clk(clk), .reset_n(reset_n), .is_max(is_max),
        .in_valid(in_valid && !sel), .in_ready(rdy_a),
        .in_data(in_data), .in_last(in_last),
        .out_valid(ov_a), .out_ready(out_ready && !sel),
        .out_data(dat_a), .out_idx(idx_a), .out_cnt(cnt_a),
        .nan_err(nan_a), .ovf_err(ovf_a)
    );

    fp32_vec_minmax #(.IDX_W(2)) u_b (
        .clk(clk), .reset_n(reset_n), .is_max(is_max),
        .in_valid(in_valid && sel), .in_ready(rdy_b),
        .in_data(in_data), .in_last(in_last),
        .out_valid(ov_b), .out_ready(out_ready && sel),
        .out_data(dat_b), .out_idx(idx_b), .out_cnt(cnt_b),
        .nan_err(nan_b), .ovf_err(ovf_b)
    );

    assign in_ready  = sel ? rdy_b : rdy_a;
    assign out_valid = sel ? ov_b : ov_a;
    assign out_data  = sel ? dat_b : dat_a;
    assign out_idx   = sel ? {6'd0, idx_b} : idx_a;
    assign out_cnt   = sel ? {6'd0, cnt_b} : cnt_a;
    assign nan_err   = sel ? nan_b : nan_a;
    assign ovf_err   = sel ? ovf_b : ovf_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [31:0] d, input logic last, input logic mode);
        int w;
        w = 0;
        in_data  = d;
        in_last  = last;
        is_max   = mode;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready got=%0b exp=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(output logic [31:0] d, output logic [7:0] idx,
                           output logic [8:0] cnt, output logic nan,
                           output logic ovf);
        int w;
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL collect_timeout got=%0b exp=1", out_valid);
        end
        d   = out_data;
        idx = out_idx;
        cnt = out_cnt;
        nan = nan_err;
        ovf = ovf_err;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_data, out_idx, out_cnt, nan_err, ovf_err, in_ready} !== 52'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got v=%0b d=%h i=%0d c=%0d n=%0b o=%0b r=%0b exp all 0",
                     out_valid, out_data, out_idx, out_cnt, nan_err, ovf_err, in_ready);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready got=%0b exp=1", in_ready);
        end
    endtask

    task automatic test_max_basic();
        logic [31:0] d; logic [7:0] i; logic [8:0] c; logic n, o;
        send(32'h4180_0000, 1'b0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL early_valid got=%0b exp=0", out_valid);
        end
        send(32'hC188_0000, 1'b1, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_valid got=%0b exp=1", out_valid);
        end
        collect(d, i, c, n, o);
        n_cmp++;
        if ({d, i, c, n, o} !== {32'h4180_0000, 8'd0, 9'd2, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL max_basic got d=%h i=%0d c=%0d n=%0b o=%0b exp d=41800000 i=0 c=2 n=0 o=0",
                     d, i, c, n, o);
        end
    endtask

    task automatic test_mode_latch();
        logic [31:0] d; logic [7:0] i; logic [8:0] c; logic n, o;
        send(32'h4180_0000, 1'b0, 1'b0);
        send(32'hC188_0000, 1'b1, 1'b1);
        collect(d, i, c, n, o);
        n_cmp++;
        if ({d, i, c} !== {32'hC188_0000, 8'd1, 9'd2}) begin
            n_bad++;
            $display("FAIL min_toggle got d=%h i=%0d c=%0d exp d=c1880000 i=1 c=2", d, i, c);
        end
        send(32'h4180_0000, 1'b0, 1'b1);
        send(32'hC188_0000, 1'b1, 1'b0);
        collect(d, i, c, n, o);
        n_cmp++;
        if ({d, i, c} !== {32'h4180_0000, 8'd0, 9'd2}) begin
            n_bad++;
            $display("FAIL max_toggle got d=%h i=%0d c=%0d exp d=41800000 i=0 c=2", d, i, c);
        end
    endtask

    task automatic test_ties();
        logic [31:0] d; logic [7:0] i; logic [8:0] c; logic n, o;
        send(32'h4040_0000, 1'b0, 1'b1);
        send(32'hFF80_0000, 1'b0, 1'b1);
        send(32'h4040_0000, 1'b0, 1'b1);
        send(32'h8000_0000, 1'b0, 1'b1);
        send(32'h0000_0000, 1'b1, 1'b1);
        collect(d, i, c, n, o);
        n_cmp++;
        if ({d, i, c} !== {32'h4040_0000, 8'd0, 9'd5}) begin
            n_bad++;
            $display("FAIL tie_max got d=%h i=%0d c=%0d exp d=40400000 i=0 c=5", d, i, c);
        end
        send(32'h0000_0000, 1'b0, 1'b0);
        send(32'h8000_0000, 1'b1, 1'b0);
        collect(d, i, c, n, o);
        n_cmp++;
        if ({d, i, c} !== {32'h0000_0000, 8'd0, 9'd2}) begin
            n_bad++;
            $display("FAIL zero_tie_min got d=%h i=%0d c=%0d exp d=00000000 i=0 c=2", d, i, c);
        end
    endtask

    task automatic test_inf_denorm();
        logic [31:0] d; logic [7:0] i; logic [8:0] c; logic n, o;
        send(32'h7F80_0000, 1'b0, 1'b0);
        send(32'h0000_0001, 1'b0, 1'b0);
        send(32'h8000_0001, 1'b1, 1'b0);
        collect(d, i, c, n, o);
        n_cmp++;
        if ({d, i, c} !== {32'h8000_0001, 8'd2, 9'd3}) begin
            n_bad++;
            $display("FAIL denorm_min got d=%h i=%0d c=%0d exp d=80000001 i=2 c=3", d, i, c);
        end
        send(32'hFF80_0000, 1'b0, 1'b1);
        send(32'h8000_0001, 1'b0, 1'b1);
        send(32'h0000_0001, 1'b0, 1'b1);
        send(32'h7F80_0000, 1'b1, 1'b1);
        collect(d, i, c, n, o);
        n_cmp++;
        if ({d, i, c} !== {32'h7F80_0000, 8'd3, 9'd4}) begin
            n_bad++;
            $display("FAIL inf_max got d=%h i=%0d c=%0d exp d=7f800000 i=3 c=4", d, i, c);
        end
    endtask

    task automatic test_nan();
        logic [31:0] d; logic [7:0] i; logic [8:0] c; logic n, o;
        send(32'h3F80_0000, 1'b0, 1'b1);
        send(32'h7FC0_0001, 1'b0, 1'b1);
        send(32'h40A0_0000, 1'b1, 1'b1);
        collect(d, i, c, n, o);
        n_cmp++;
        if ({d, i, c, n, o} !== {32'h7FC0_0000, 8'd1, 9'd3, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL nan_freeze got d=%h i=%0d c=%0d n=%0b o=%0b exp d=7fc00000 i=1 c=3 n=1 o=0",
                     d, i, c, n, o);
        end
    endtask

    task automatic test_ovf();
        logic [31:0] d; logic [7:0] i; logic [8:0] c; logic n, o;
        sel = 1'b1;
        send(32'h3F80_0000, 1'b0, 1'b1);
        send(32'h4000_0000, 1'b0, 1'b1);
        send(32'h4040_0000, 1'b0, 1'b1);
        send(32'h4080_0000, 1'b0, 1'b1);
        send(32'h40A0_0000, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, in_ready, out_data, out_idx, out_cnt, ovf_err, nan_err} !==
                {1'b1, 1'b0, 32'h4080_0000, 8'd3, 9'd4, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL ovf_hold cyc=%0d got v=%0b r=%0b d=%h i=%0d c=%0d o=%0b n=%0b exp v=1 r=0 d=40800000 i=3 c=4 o=1 n=0",
                         k, out_valid, in_ready, out_data, out_idx, out_cnt, ovf_err, nan_err);
            end
        end
        collect(d, i, c, n, o);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_release got=%0b exp=0", out_valid);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [7:0] i; logic [8:0] c; logic n, o;
        logic seen;
        send(32'h3F80_0000, 1'b0, 1'b1);
        send(32'h4000_0000, 1'b0, 1'b1);
        send(32'h4040_0000, 1'b0, 1'b1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_valid got=%0b exp=0", seen);
        end
        send(32'h4000_0000, 1'b1, 1'b1);
        collect(d, i, c, n, o);
        n_cmp++;
        if ({d, i, c, n, o} !== {32'h4000_0000, 8'd0, 9'd1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL after_reset got d=%h i=%0d c=%0d n=%0b o=%0b exp d=40000000 i=0 c=1 n=0 o=0",
                     d, i, c, n, o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [7:0] i; logic [8:0] c; logic n, o;
        send(32'hBF80_0000, 1'b1, 1'b0);
        collect(d, i, c, n, o);
        n_cmp++;
        if ({d, i, c} !== {32'hBF80_0000, 8'd0, 9'd1}) begin
            n_bad++;
            $display("FAIL single got d=%h i=%0d c=%0d exp d=bf800000 i=0 c=1", d, i, c);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready got=%0b exp=1", in_ready);
        end
        send(32'h4000_0000, 1'b0, 1'b0);
        send(32'h3F80_0000, 1'b1, 1'b0);
        collect(d, i, c, n, o);
        n_cmp++;
        if ({d, i, c} !== {32'h3F80_0000, 8'd1, 9'd2}) begin
            n_bad++;
            $display("FAIL b2b_min got d=%h i=%0d c=%0d exp d=3f800000 i=1 c=2", d, i, c);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        sel       = 1'b0;
        reset_n   = 1'b0;
        is_max    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_max_basic();
        test_mode_latch();
        test_ties();
        test_inf_denorm();
        test_nan();
        test_ovf();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
